// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity-bit helper.
// Also intended for use by the receive side of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // acc is the XOR of all data bits; odd parity inverts it so the frame's ones count is odd.
    function automatic logic parity_bit(input int mode, input logic acc);
        return (mode == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmit path: one-entry holding register feeding a baud-tick-paced serialiser.
// Frame is start, DATABITS data bits LSB first, optional parity, STOPBITS stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baudtick,
    input  logic [DATABITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                txd,
    output logic                busy
);

    localparam logic [3:0] DATA_LAST = 4'(DATABITS);
    localparam logic [3:0] STOP_LAST = 4'(STOPBITS);

    uart_state_e         state_q, state_d;
    logic [DATABITS-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [DATABITS-1:0] shift_q, shift_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                par_q, par_d;
    logic                txd_q, txd_d;
    logic                in_ready_q;
    logic                busy_q;
    logic                load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        txd_d       = txd_q;
        load        = 1'b0;

        if (in_valid && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (baudtick) begin
            case (state_q)
                ST_IDLE: load = hold_full_q;
                ST_START: begin
                    txd_d   = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = 4'd1;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_q < DATA_LAST) begin
                        txd_d   = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (PARITY != PAR_NONE) begin
                        txd_d   = parity_bit(PARITY, par_q);
                        state_d = ST_PARITY;
                    end else begin
                        txd_d   = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    txd_d   = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    // The counter is reused to count stop-bit intervals already sent.
                    if (cnt_q >= STOP_LAST) begin
                        state_d = ST_IDLE;
                        load    = hold_full_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Loading frees the holding register; an accept on this cycle is impossible.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
            par_d       = 1'b0;
            cnt_d       = 4'd0;
            state_d     = ST_START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= 4'd0;
            par_q       <= 1'b0;
            txd_q       <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            txd_q       <= txd_d;
            in_ready_q  <= !hold_full_d;
            busy_q      <= hold_full_d || (state_d != ST_IDLE);
        end
    end

    assign in_ready = in_ready_q;
    assign txd      = txd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of framed bytes across parity variants,
// plus back-to-back, stalled-input, mid-frame reset and tick-tied-high sequences.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       vld [4];
    logic       txd_w [4];
    logic       rdy_w [4];
    logic       busy_w [4];

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          len;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 with baudtick tied high
    uart_transmitter #(.DATABITS(8), .PARITY(0), .STOPBITS(1)) u_n1 (
        .clk(clk), .rst(rst), .baudtick(tick), .in_data(in_data), .in_valid(vld[0]),
        .in_ready(rdy_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
    uart_transmitter #(.DATABITS(8), .PARITY(2), .STOPBITS(1)) u_e1 (
        .clk(clk), .rst(rst), .baudtick(tick), .in_data(in_data), .in_valid(vld[1]),
        .in_ready(rdy_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
    uart_transmitter #(.DATABITS(8), .PARITY(1), .STOPBITS(1)) u_o1 (
        .clk(clk), .rst(rst), .baudtick(tick), .in_data(in_data), .in_valid(vld[2]),
        .in_ready(rdy_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));
    uart_transmitter #(.DATABITS(8), .PARITY(0), .STOPBITS(2)) u_n2 (
        .clk(clk), .rst(rst), .baudtick(1'b1), .in_data(in_data), .in_valid(vld[3]),
        .in_ready(rdy_w[3]), .txd(txd_w[3]), .busy(busy_w[3]));

    // Baud tick every 16 clk, high across exactly one rising edge
    initial begin
        forever begin
            repeat (15) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Wait for the next baud tick, then sample txd on the falling edge after it.
    task automatic next_bit(input int d, output logic b);
        int guard = 0;
        while (!tick && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!tick) begin
            n_chk++;
            $display("FAIL tick_wait: got no baud tick, expected one within 40 clk");
        end
        @(negedge clk);
        b = txd_w[d];
    endtask

    task automatic send(input int d, input logic [7:0] v);
        in_data = v;
        vld[d]  = 1'b1;
        @(negedge clk);
        vld[d]  = 1'b0;
    endtask

    task automatic idle_check(input int d, input string nm);
        logic b;
        next_bit(d, b);
        check(nm, {29'd0, b, rdy_w[d], busy_w[d]}, 32'b110);
    endtask

    initial begin
        logic        b;
        logic        r9, r10, r0, r1;
        logic [31:0] f;
        logic [11:0] tv, bv;

        for (int d = 0; d < 4; d++) vld[d] = 1'b0;
        tbl[0] = '{0, 8'h55, 10, 32'h2AA};
        tbl[1] = '{0, 8'h3C, 10, 32'h278};
        tbl[2] = '{0, 8'hFF, 10, 32'h3FE};
        tbl[3] = '{0, 8'h00, 10, 32'h200};
        tbl[4] = '{1, 8'hA5, 11, 32'h54A};
        tbl[5] = '{2, 8'hA5, 11, 32'h74A};
        tbl[6] = '{1, 8'h07, 11, 32'h60E};
        tbl[7] = '{2, 8'h07, 11, 32'h40E};
        tbl[8] = '{0, 8'h80, 10, 32'h300};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++)
            check($sformatf("reset_state%0d", d), {29'd0, txd_w[d], rdy_w[d], busy_w[d]}, 32'b110);
        rst = 1'b0;
        @(negedge clk);

        // Tick tied high, 8N2, 0x00: low 9 clk, high 2 clk, then idle
        in_data = 8'h00;
        vld[3]  = 1'b1;
        @(negedge clk);
        vld[3]  = 1'b0;
        r0 = rdy_w[3];
        r1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tv[i] = txd_w[3];
            bv[i] = busy_w[3];
            if (i == 0) r1 = rdy_w[3];
        end
        check("fast_txd", {20'd0, tv}, 32'hE00);
        check("fast_busy", {20'd0, bv}, 32'h7FF);
        check("fast_rdy", {30'd0, r0, r1}, 32'b01);

        for (int k = 0; k < 9; k++) begin
            send(tbl[k].sel, tbl[k].data);
            check($sformatf("accept%0d", k), {30'd0, rdy_w[tbl[k].sel], busy_w[tbl[k].sel]}, 32'b01);
            f = 32'd0;
            next_bit(tbl[k].sel, b);
            f[0] = b;
            check($sformatf("reload_rdy%0d", k), {31'd0, rdy_w[tbl[k].sel]}, 32'd1);
            for (int i = 1; i < tbl[k].len; i++) begin
                next_bit(tbl[k].sel, b);
                f[i] = b;
            end
            check($sformatf("frame%0d", k), f, tbl[k].exp);
            idle_check(tbl[k].sel, $sformatf("idle%0d", k));
        end

        // Back-to-back 0x01 then 0x80, second accepted while the first shifts
        send(0, 8'h01);
        f = 32'd0;
        next_bit(0, b);
        f[0] = b;
        send(0, 8'h80);
        check("b2b_hold_full", {31'd0, rdy_w[0]}, 32'd0);
        r9 = 1'b1;
        r10 = 1'b0;
        for (int i = 1; i < 20; i++) begin
            next_bit(0, b);
            f[i] = b;
            if (i == 9) r9 = rdy_w[0];
            if (i == 10) r10 = rdy_w[0];
        end
        check("b2b_frames", f, 32'hC0202);
        check("b2b_rdy", {30'd0, r9, r10}, 32'b01);
        idle_check(0, "b2b_idle");

        // in_valid held with changing data while the holding register is full
        send(0, 8'h3C);
        f = 32'd0;
        next_bit(0, b);
        f[0] = b;
        send(0, 8'h01);
        vld[0] = 1'b1;
        fork
            begin
                for (int i = 1; i < 20; i++) begin
                    next_bit(0, b);
                    f[i] = b;
                end
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    in_data = in_data + 8'h25;
                    @(negedge clk);
                end
                vld[0] = 1'b0;
            end
        join
        check("stall_frames", f, 32'h80A78);
        idle_check(0, "stall_idle");

        // Reset during the fourth data bit of 0xFF
        send(0, 8'hFF);
        f = 32'd0;
        for (int i = 0; i < 5; i++) begin
            next_bit(0, b);
            f[i] = b;
        end
        check("pre_rst_bits", f, 32'h1E);
        #3 rst = 1'b1;
        #1 check("rst_async", {29'd0, txd_w[0], rdy_w[0], busy_w[0]}, 32'b110);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h3C);
        f = 32'd0;
        for (int i = 0; i < 10; i++) begin
            next_bit(0, b);
            f[i] = b;
        end
        check("post_rst_frame", f, 32'h278);
        idle_check(0, "post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
